game_timer_ctrl: RTL

- Countdown game-timer controller that sequences the one-second tick generator for the VGA game.
- Consumes the generator's single-cycle tick and drives its turbo input and a phase-align reset.
- Keeps an M:SS BCD countdown for the on-screen score/time digits, with IDLE/RUN/PAUSE/DONE control from debounced key pulses.
- Raises warning and expiry flags for the game FSM.

---
 rtl/game_timer_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/game_timer_ctrl.sv
// M:SS BCD countdown controller that sequences the one-second tick generator.
// Optional bonus-time adder is enabled with TIMER_BONUS_EN.
//
// state   | meaning
// S_IDLE  | loaded with start value, waiting for start
// S_RUN   | counting down on one_sec
// S_PAUSE | counting frozen, waiting for start
// S_DONE  | reached 0:00, waiting for restart
module game_timer_ctrl #(
    parameter int START_MIN = 1,
    parameter int START_SEC = 30,
    parameter int WARN_SEC  = 10,
    parameter int BONUS_SEC = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic       pause,
    input  logic       restart,
    input  logic       hurry,
    input  logic       add_bonus,
    input  logic       one_sec,
    output logic       turbo,
    output logic       tick_rstN,
    output logic [3:0] min_d,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       running,
    output logic       warn,
    output logic       expired,
    output logic       time_up
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [11:0] START_V = {4'(START_MIN), 4'(START_SEC / 10), 4'(START_SEC % 10)};
    localparam logic [9:0]  WARN_V  = 10'(WARN_SEC);

    state_t     state_q, state_d;
    logic [3:0] mins_q, mins_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       warn_q, warn_d;
    logic       expired_q, expired_d;
    logic       tick_rstn_q, tick_rstn_d;

    logic [11:0] cur, nxt;

    // Caller guarantees v is nonzero, so the minutes borrow never underflows.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] m, t, o;
        {m, t, o} = v;
        if (o != 4'd0) begin
            o = o - 4'd1;
        end else begin
            o = 4'd9;
            if (t != 4'd0) begin
                t = t - 4'd1;
            end else begin
                t = 4'd5;
                m = m - 4'd1;
            end
        end
        return {m, t, o};
    endfunction

    function automatic logic [9:0] bcd_total(input logic [11:0] v);
        return 10'(v[11:8]) * 10'd60 + 10'(v[7:4]) * 10'd10 + 10'(v[3:0]);
    endfunction

`ifdef TIMER_BONUS_EN
    localparam logic [4:0] BON_T = 5'(BONUS_SEC / 10);
    localparam logic [4:0] BON_O = 5'(BONUS_SEC % 10);

    function automatic logic [11:0] bcd_add(input logic [11:0] v);
        logic [4:0] m5, t5, o5;
        o5 = {1'b0, v[3:0]} + BON_O;
        t5 = {1'b0, v[7:4]} + BON_T;
        m5 = {1'b0, v[11:8]};
        if (o5 >= 5'd10) begin
            o5 = o5 - 5'd10;
            t5 = t5 + 5'd1;
        end
        if (t5 >= 5'd6) begin
            t5 = t5 - 5'd6;
            m5 = m5 + 5'd1;
        end
        if (m5 > 5'd9) begin
            return 12'h959;
        end
        return {m5[3:0], t5[3:0], o5[3:0]};
    endfunction
`else
    logic unused_bonus;
    assign unused_bonus = add_bonus ^ (BONUS_SEC != 0);
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            mins_q      <= START_V[11:8];
            tens_q      <= START_V[7:4];
            ones_q      <= START_V[3:0];
            warn_q      <= 1'b0;
            expired_q   <= 1'b0;
            tick_rstn_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            mins_q      <= mins_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            warn_q      <= warn_d;
            expired_q   <= expired_d;
            tick_rstn_q <= tick_rstn_d;
        end
    end

    always_comb begin
        cur         = {mins_q, tens_q, ones_q};
        nxt         = cur;
        state_d     = state_q;
        expired_d   = 1'b0;
        tick_rstn_d = 1'b1;
        if (restart) begin
            state_d     = S_IDLE;
            nxt         = START_V;
            tick_rstn_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d     = S_RUN;
                        tick_rstn_d = 1'b0;
                    end
                end
                S_RUN: begin
                    // start outranks pause; a tick coinciding with pause is dropped
                    if (pause && !start) begin
                        state_d = S_PAUSE;
                    end else if (one_sec) begin
                        nxt = bcd_dec(cur);
                    end
`ifdef TIMER_BONUS_EN
                    if (add_bonus) begin
                        nxt = bcd_add(nxt);
                    end
`endif
                    if (state_d == S_RUN && one_sec && nxt == 12'h000) begin
                        state_d   = S_DONE;
                        expired_d = 1'b1;
                    end
                end
                S_PAUSE: begin
`ifdef TIMER_BONUS_EN
                    if (add_bonus) begin
                        nxt = bcd_add(cur);
                    end
`endif
                    if (start) begin
                        state_d     = S_RUN;
                        tick_rstn_d = 1'b0;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        {mins_d, tens_d, ones_d} = nxt;
        warn_d = ((state_d == S_RUN) || (state_d == S_PAUSE)) && (bcd_total(nxt) <= WARN_V);
    end

    assign min_d     = mins_q;
    assign sec_t     = tens_q;
    assign sec_o     = ones_q;
    assign warn      = warn_q;
    assign expired   = expired_q;
    assign tick_rstN = tick_rstn_q;
    assign running   = (state_q == S_RUN);
    assign time_up   = (state_q == S_DONE);
    assign turbo     = hurry && (state_q == S_RUN);

endmodule
